// File: rtl/id_hazard_ctrl.sv
// Decode-stage register scoreboard: counts in-flight GPR writes between ID issue
// and WB retire and stalls ID whenever a source or a saturated destination is pending.
module id_hazard_ctrl #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_raddr1,
  input  logic [4:0]       id_raddr2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_we,
  input  logic [4:0]       id_waddr,
  input  logic             id_fire,
  input  logic             wb_fire,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic             flush,
  output logic             stall,
  output logic             pending_any,
  output logic [CNT_W+2:0] inflight,
  output logic             err
);

  localparam int IW = CNT_W + 3;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_r1;
  logic [CNT_W-1:0] cnt_r2;
  logic [CNT_W-1:0] cnt_w;
  logic [CNT_W-1:0] cnt_wb;
  logic             inc;
  logic             dec;
  logic             dec_ok;
  logic             eff_inc;
  logic             same_reg;
  logic             raw1;
  logic             raw2;
  logic             waw_sat;

  assign cnt_r1 = cnt[id_raddr1];
  assign cnt_r2 = cnt[id_raddr2];
  assign cnt_w  = cnt[id_waddr];
  assign cnt_wb = cnt[wb_waddr];

  assign inc      = id_fire & id_we & (id_waddr != 5'd0);
  assign dec      = wb_fire & wb_we & (wb_waddr != 5'd0);
  assign same_reg = (id_waddr == wb_waddr);

  // A retire against an empty counter is an error and is ignored entirely.
  assign dec_ok = dec & (cnt_wb != '0);

  // An issue into a saturated counter only counts if a retire frees that slot.
  assign eff_inc = inc & ((cnt_w != MAX) | (dec_ok & same_reg));

  assign raw1    = id_use1 & (id_raddr1 != 5'd0) & (cnt_r1 != '0);
  assign raw2    = id_use2 & (id_raddr2 != 5'd0) & (cnt_r2 != '0);
  assign waw_sat = id_we & (id_waddr != 5'd0) & (cnt_w == MAX);

  // Registered counters only: a same-cycle retire still stalls, since the
  // regfile is written at the end of the WB cycle.
  assign stall = id_valid & (raw1 | raw2 | waw_sat);

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [CNT_W-1:0] q;
    logic             hit_inc;
    logic             hit_dec;

    assign hit_inc = inc & (id_waddr == 5'(r));
    assign hit_dec = dec_ok & (wb_waddr == 5'(r));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        q <= '0;
      end else if (flush) begin
        q <= '0;
      end else if (hit_inc && !hit_dec && (q != MAX)) begin
        q <= q + 1'b1;
      end else if (hit_dec && !hit_inc) begin
        q <= q - 1'b1;
      end
    end

    assign cnt[r] = q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + IW'(eff_inc) - IW'(dec_ok);
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if ((id_fire & stall) | (dec & ~dec_ok)) begin
      err <= 1'b1;
    end
  end

  assign pending_any = (inflight != '0);

endmodule
